// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_share_arbiter : two valid/ready requesters sharing one ALU, with a   |
// | registered per-port response channel.             Rev 1.0               |
// +--------------------------------------------------------------------------+

module alu_module (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  localparam logic [3:0] c_alu_add  = 4'h0;
  localparam logic [3:0] c_alu_sub  = 4'h1;
  localparam logic [3:0] c_alu_and  = 4'h2;
  localparam logic [3:0] c_alu_or   = 4'h3;
  localparam logic [3:0] c_alu_xor  = 4'h4;
  localparam logic [3:0] c_alu_sll  = 4'h5;
  localparam logic [3:0] c_alu_srl  = 4'h6;
  localparam logic [3:0] c_alu_sra  = 4'h7;
  localparam logic [3:0] c_alu_slt  = 4'h8;
  localparam logic [3:0] c_alu_sltu = 4'h9;

  always_comb begin
    y = 32'h0;
    case (op)
      c_alu_add:  y = a + b;
      c_alu_sub:  y = a - b;
      c_alu_and:  y = a & b;
      c_alu_or:   y = a | b;
      c_alu_xor:  y = a ^ b;
      c_alu_sll:  y = a << b[4:0];
      c_alu_srl:  y = a >> b[4:0];
      c_alu_sra:  y = $unsigned($signed(a) >>> b[4:0]);
      c_alu_slt:  y = {31'h0, $signed(a) < $signed(b)};
      c_alu_sltu: y = {31'h0, a < b};
      default:    y = 32'h0;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_op,
  input  logic [31:0]          req0_a,
  input  logic [31:0]          req0_b,
  output logic                 rsp0_valid,
  output logic [31:0]          rsp0_result,
  input  logic                 rsp0_ready,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_op,
  input  logic [31:0]          req1_a,
  input  logic [31:0]          req1_b,
  output logic                 rsp1_valid,
  output logic [31:0]          rsp1_result,
  input  logic                 rsp1_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] done0_cnt,
  output logic [CNT_WIDTH-1:0] done1_cnt
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0]  r_state;
  logic        r_owner;
  logic        r_last_grant;
  logic [1:0]  w_req_valid;
  logic [1:0]  w_rsp_ready;
  logic [1:0]  w_rsp_valid;
  logic [1:0]  w_rsp_fire;
  logic [1:0]  w_grant;
  logic        w_owner_fire;
  logic        w_can_accept;
  logic        w_accept;
  logic        w_sel;
  logic [3:0]  w_alu_op;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;

  assign w_req_valid  = {req1_valid, req0_valid};
  assign w_rsp_ready  = {rsp1_ready, rsp0_ready};
  assign w_rsp_valid  = {g_port[1].r_rsp_valid, g_port[0].r_rsp_valid};
  assign w_rsp_fire   = w_rsp_valid & w_rsp_ready;
  assign w_owner_fire = (r_state == S_PEND) & w_rsp_fire[r_owner];
  // A new operation may enter in the same cycle the held result drains.
  assign w_can_accept = (r_state == S_IDLE) | w_owner_fire;

  always_comb begin
    w_grant = 2'b00;
    if (w_can_accept) begin
      case (w_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11: begin
          if ((PRIORITY_MODE != 0) || r_last_grant) w_grant = 2'b01;
          else                                      w_grant = 2'b10;
        end
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_accept   = |w_grant;
  assign w_sel      = w_grant[1];
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  assign w_alu_op = w_sel ? req1_op : req0_op;
  assign w_alu_a  = w_sel ? req1_a  : req0_a;
  assign w_alu_b  = w_sel ? req1_b  : req0_b;

  alu_module u_alu (
    .op (w_alu_op),
    .a  (w_alu_a),
    .b  (w_alu_b),
    .y  (w_alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_state      <= S_PEND;
      r_owner      <= w_sel;
      r_last_grant <= w_sel;
    end else if (w_owner_fire) begin
      r_state      <= S_IDLE;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_result;
    logic [CNT_WIDTH-1:0] r_done_cnt;

    // Result register keeps its last value when idle; valid alone qualifies it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rsp_valid  <= 1'b0;
        r_rsp_result <= 32'h0;
        r_done_cnt   <= '0;
      end else begin
        if (w_grant[p]) begin
          r_rsp_valid  <= 1'b1;
          r_rsp_result <= w_alu_y;
        end else if (w_rsp_fire[p]) begin
          r_rsp_valid  <= 1'b0;
        end
        if (w_rsp_fire[p]) r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign rsp0_valid  = g_port[0].r_rsp_valid;
  assign rsp0_result = g_port[0].r_rsp_result;
  assign rsp1_valid  = g_port[1].r_rsp_valid;
  assign rsp1_result = g_port[1].r_rsp_result;
  assign done0_cnt   = g_port[0].r_done_cnt;
  assign done1_cnt   = g_port[1].r_done_cnt;
  assign busy        = (r_state == S_PEND);

`ifndef SYNTHESIS
  a_one_grant : assert property (@(posedge clk) disable iff (rst) $onehot0(w_grant));
  a_one_rsp   : assert property (@(posedge clk) disable iff (rst)
                                 $countones(w_rsp_valid) == 32'(busy));
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_share_arbiter : directed vector bench, round-robin and fixed-     |
// | priority instances driven from the same stimulus.  Rev 1.0              |
// +--------------------------------------------------------------------------+

module tb_alu_share_arbiter;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_BAD  = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;

  logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid, rr_busy;
  logic [31:0] rr_rsp0_result, rr_rsp1_result;
  logic [15:0] rr_done0_cnt, rr_done1_cnt;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
  logic [31:0] fp_rsp0_result, fp_rsp1_result;
  logic [1:0]  fp_done0_cnt, fp_done1_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.PRIORITY_MODE(0), .CNT_WIDTH(16)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rr_rsp0_valid), .rsp0_result(rr_rsp0_result), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rr_rsp1_valid), .rsp1_result(rr_rsp1_result), .rsp1_ready(rsp1_ready),
    .busy(rr_busy), .done0_cnt(rr_done0_cnt), .done1_cnt(rr_done1_cnt)
  );

  // Narrow counters on this instance make the wrap reachable in a few cycles.
  alu_share_arbiter #(.PRIORITY_MODE(1), .CNT_WIDTH(2)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(fp_rsp0_valid), .rsp0_result(fp_rsp0_result), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(fp_rsp1_valid), .rsp1_result(fp_rsp1_result), .rsp1_ready(rsp1_ready),
    .busy(fp_busy), .done0_cnt(fp_done0_cnt), .done1_cnt(fp_done1_cnt)
  );

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int exp_done0, exp_done1;
    logic g;

    vt[0]  = '{1'b0, OP_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vt[1]  = '{1'b1, OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vt[2]  = '{1'b0, OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vt[3]  = '{1'b1, OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
    vt[4]  = '{1'b0, OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vt[5]  = '{1'b1, OP_SLL,  32'h00000001, 32'h0000003F, 32'h80000000};
    vt[6]  = '{1'b0, OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000};
    vt[7]  = '{1'b1, OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000};
    vt[8]  = '{1'b0, OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vt[9]  = '{1'b1, OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vt[10] = '{1'b0, OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    vt[11] = '{1'b1, OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vt[12] = '{1'b0, OP_BAD,  32'h12345678, 32'h9ABCDEF0, 32'h00000000};

    // Reset state
    @(negedge clk);
    check("reset rsp0_valid", 32'(rr_rsp0_valid), 0);
    check("reset rsp1_valid", 32'(rr_rsp1_valid), 0);
    check("reset rsp0_result", rr_rsp0_result, 0);
    check("reset busy", 32'(rr_busy), 0);
    check("reset done0", 32'(rr_done0_cnt), 0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 0;

    // Single operations from the vector table
    exp_done0 = 0; exp_done1 = 0;
    for (int i = 0; i < 13; i++) begin
      if (vt[i].port) begin
        req1_valid = 1; req1_op = vt[i].op; req1_a = vt[i].a; req1_b = vt[i].b;
      end else begin
        req0_valid = 1; req0_op = vt[i].op; req0_a = vt[i].a; req0_b = vt[i].b;
      end
      @(negedge clk);
      check($sformatf("vec%0d req_ready", i),
            32'(vt[i].port ? rr_req1_ready : rr_req0_ready), 1);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      check($sformatf("vec%0d rsp_valid", i),
            32'(vt[i].port ? rr_rsp1_valid : rr_rsp0_valid), 1);
      check($sformatf("vec%0d result", i),
            vt[i].port ? rr_rsp1_result : rr_rsp0_result, vt[i].exp);
      if (vt[i].port) exp_done1++; else exp_done0++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("table done0", 32'(rr_done0_cnt), 32'(exp_done0));
    check("table done1", 32'(rr_done1_cnt), 32'(exp_done1));
    check("table busy idle", 32'(rr_busy), 0);

    // Contention: round-robin alternates, fixed priority always picks port 0
    do_reset();
    req0_valid = 1; req0_op = OP_SUB; req0_a = 32'd5; req0_b = 32'd7;
    req1_valid = 1; req1_op = OP_SRA; req1_a = 32'h80000000; req1_b = 32'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr c%0d req0_ready", i), 32'(rr_req0_ready), 32'(i % 2 == 0));
      check($sformatf("rr c%0d req1_ready", i), 32'(rr_req1_ready), 32'(i % 2 == 1));
      check($sformatf("fp c%0d req0_ready", i), 32'(fp_req0_ready), 1);
      check($sformatf("fp c%0d req1_ready", i), 32'(fp_req1_ready), 0);
      if (i > 0) begin
        g = ((i - 1) % 2 == 1);
        check($sformatf("rr c%0d rsp_valid", i), 32'(g ? rr_rsp1_valid : rr_rsp0_valid), 1);
        check($sformatf("rr c%0d result", i), g ? rr_rsp1_result : rr_rsp0_result,
              g ? 32'hF8000000 : 32'hFFFFFFFE);
        check($sformatf("fp c%0d result", i), fp_rsp0_result, 32'hFFFFFFFE);
      end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("rr c4 rsp1_valid", 32'(rr_rsp1_valid), 1);
    check("rr c4 rsp1_result", rr_rsp1_result, 32'hF8000000);
    check("rr c4 done0", 32'(rr_done0_cnt), 2);
    check("rr c4 done1", 32'(rr_done1_cnt), 1);
    check("fp c4 done0", 32'(fp_done0_cnt), 3);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr c5 done1", 32'(rr_done1_cnt), 2);
    check("rr c5 busy", 32'(rr_busy), 0);
    check("fp done0 wrap", 32'(fp_done0_cnt), 0);
    check("fp done1", 32'(fp_done1_cnt), 0);

    // Backpressure on port 1, port 0 waits then enters on the drain cycle
    do_reset();
    rsp1_ready = 0;
    req1_valid = 1; req1_op = OP_SLTU; req1_a = 32'd1; req1_b = 32'hFFFFFFFF;
    @(negedge clk);
    check("bp req1_ready", 32'(rr_req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 32'd3; req0_b = 32'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d rsp1_valid", k), 32'(rr_rsp1_valid), 1);
      check($sformatf("bp%0d rsp1_result", k), rr_rsp1_result, 1);
      check($sformatf("bp%0d busy", k), 32'(rr_busy), 1);
      check($sformatf("bp%0d req0_ready", k), 32'(rr_req0_ready), 0);
      check($sformatf("bp%0d req1_ready", k), 32'(rr_req1_ready), 0);
      @(posedge clk); #1;
    end
    rsp1_ready = 1;
    @(negedge clk);
    check("bp drain req0_ready", 32'(rr_req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0; rsp1_ready = 0; rsp0_ready = 0;
    @(negedge clk);
    check("bp rsp0_valid", 32'(rr_rsp0_valid), 1);
    check("bp rsp0_result", rr_rsp0_result, 32'd7);
    check("bp rsp1_valid low", 32'(rr_rsp1_valid), 0);
    check("bp done1", 32'(rr_done1_cnt), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold rsp0_valid", 32'(rr_rsp0_valid), 1);
    check("hold busy", 32'(rr_busy), 1);

    // Asynchronous reset while pending, no clock edge in between
    rst = 1;
    #1;
    check("async rsp0_valid", 32'(rr_rsp0_valid), 0);
    check("async busy", 32'(rr_busy), 0);
    check("async done1", 32'(rr_done1_cnt), 0);
    check("async rsp0_result", rr_rsp0_result, 0);
    rst = 0;
    #1;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = OP_OR;  req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    check("post-rst rsp0_valid", 32'(rr_rsp0_valid), 0);
    check("post-rst req0_ready", 32'(rr_req0_ready), 1);
    check("post-rst req1_ready", 32'(rr_req1_ready), 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("post-rst rsp0_result", rr_rsp0_result, 32'd3);
    check("post-rst rsp0_valid2", 32'(rr_rsp0_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
